pack_n_to_w: RTL and testbench

- Parametrised narrow-to-wide packer with symbol alignment. Generalises the fixed 8-to-32 converter to any IN_W x RATIO on a single clock.
- Accepts IN_W-bit symbols at symbol rate and aligns lane 0 to the COM symbol. Packs RATIO symbols into one OUT_W word.
- Declares lock (sinc) after LOCK_CNT clean words.
- Sits between the descrambler/decoder and the wide PHY datapath.

---
 rtl/pack_pkg.sv | 8 +
 rtl/com_align_fsm.sv | 57 +++++
 rtl/pack_n_to_w.sv | 111 +++++++++++
 tb/tb_pack_n_to_w.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/pack_pkg.sv
// pack_pkg: shared state encoding, default COM symbol and counter-width helper for pack_n_to_w.
package pack_pkg;
  typedef enum logic [1:0] {HUNT = 2'd0, ALIGN = 2'd1, LOCKED = 2'd2} state_t;
  localparam logic [7:0] COM_DEFAULT = 8'hBC;
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/com_align_fsm.sv
// com_align_fsm: HUNT/ALIGN/LOCKED tracking, lock counter, sinc and err_align generation.
module com_align_fsm
  import pack_pkg::*;
#(
  parameter int LOCK_CNT = 4
) (
  input  logic   clk_f,
  input  logic   reset,
  input  logic   acc,
  input  logic   is_com,
  input  logic   lane_zero,
  input  logic   word_done,
  output state_t state,
  output logic   sinc,
  output logic   err_align
);
  localparam int CW = cnt_w(LOCK_CNT + 1);
  state_t state_q, state_d;
  logic [CW-1:0] lock_q, lock_d;
  logic sinc_q, sinc_d, err_q, err_d, misalign;
  always_comb begin
    misalign = acc && is_com && !lane_zero && state_q != HUNT;
    state_d = state_q;
    lock_d = lock_q;
    err_d = 1'b0;
    if (state_q == HUNT) begin
      state_d = (acc && is_com) ? ALIGN : HUNT;
    end else if (misalign) begin
      state_d = ALIGN;
      lock_d = '0;
      err_d = state_q == LOCKED;
    end else if (word_done && state_q == ALIGN) begin
      lock_d = lock_q + 1'b1;
      if (lock_d == CW'(LOCK_CNT)) begin
        state_d = LOCKED;
        lock_d = '0;
      end
    end
    sinc_d = state_d == LOCKED;
  end
  always_ff @(posedge clk_f or negedge reset) begin
    if (!reset) begin
      state_q <= HUNT;
      lock_q <= '0;
      sinc_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lock_q <= lock_d;
      sinc_q <= sinc_d;
      err_q <= err_d;
    end
  end
  assign state = state_q;
  assign sinc = sinc_q;
  assign err_align = err_q;
endmodule

// File: rtl/pack_n_to_w.sv
// pack_n_to_w: aligns IN_W-bit symbols to COM and packs RATIO of them into one OUT_W word.
// Optional PACK_FLUSH_EN: emits partial words on input gaps while locked, with be_out lane marks.
module pack_n_to_w
  import pack_pkg::*;
#(
  parameter int               IN_W     = 8,
  parameter int               RATIO    = 4,
  parameter logic [IN_W-1:0]  COM_SYM  = IN_W'(COM_DEFAULT),
  parameter int               LOCK_CNT = 4,
  localparam int              OUT_W    = IN_W * RATIO
) (
  input  logic             clk_f,
  input  logic             reset,
  input  logic [IN_W-1:0]  data_input,
  input  logic             valid_input,
  output logic [OUT_W-1:0] data_out,
  output logic             valid_out,
  output logic             sinc,
`ifdef PACK_FLUSH_EN
  output logic [RATIO-1:0] be_out,
`endif
  output logic             err_align
);
  localparam int LW = cnt_w(RATIO);
  state_t state;
  logic is_com, lane_zero, word_done, valid_q, valid_d;
  logic [LW-1:0] lane_q, lane_d;
  logic [OUT_W-1:0] part_q, part_d, word, data_q, data_d;
`ifdef PACK_FLUSH_EN
  logic [RATIO-1:0] be_q, be_d;
`endif
  always_comb begin
    is_com = data_input == COM_SYM;
    lane_zero = lane_q == '0;
    word_done = valid_input && !is_com && state != HUNT && lane_q == LW'(RATIO - 1);
    word = part_q;
    for (int i = 0; i < RATIO; i++)
      if (lane_q == LW'(i)) word[OUT_W-1-i*IN_W -: IN_W] = data_input;
    lane_d = lane_q;
    part_d = part_q;
    data_d = data_q;
    valid_d = 1'b0;
`ifdef PACK_FLUSH_EN
    be_d = be_q;
`endif
    // A COM in HUNT or at a non-zero lane restarts the word with COM in lane 0
    if (valid_input && is_com && (state == HUNT || !lane_zero)) begin
      part_d = {COM_SYM, {(OUT_W - IN_W){1'b0}}};
      lane_d = LW'(1);
    end else if (valid_input && state != HUNT) begin
      if (word_done) begin
        part_d = '0;
        lane_d = '0;
        if (state == LOCKED) begin
          data_d = word;
          valid_d = 1'b1;
`ifdef PACK_FLUSH_EN
          be_d = '1;
`endif
        end
      end else begin
        part_d = word;
        lane_d = lane_q + 1'b1;
      end
    end
`ifdef PACK_FLUSH_EN
    else if (!valid_input && state == LOCKED && !lane_zero) begin
      data_d = part_q;
      valid_d = 1'b1;
      be_d = ~({RATIO{1'b1}} >> lane_q);
      part_d = '0;
      lane_d = '0;
    end
`endif
  end
  always_ff @(posedge clk_f or negedge reset) begin
    if (!reset) begin
      lane_q <= '0;
      part_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
`ifdef PACK_FLUSH_EN
      be_q <= '0;
`endif
    end else begin
      lane_q <= lane_d;
      part_q <= part_d;
      data_q <= data_d;
      valid_q <= valid_d;
`ifdef PACK_FLUSH_EN
      be_q <= be_d;
`endif
    end
  end
  com_align_fsm #(.LOCK_CNT(LOCK_CNT)) u_fsm (
    .clk_f    (clk_f),
    .reset    (reset),
    .acc      (valid_input),
    .is_com   (is_com),
    .lane_zero(lane_zero),
    .word_done(word_done),
    .state    (state),
    .sinc     (sinc),
    .err_align(err_align)
  );
  assign data_out = data_q;
  assign valid_out = valid_q;
`ifdef PACK_FLUSH_EN
  assign be_out = be_q;
`endif
endmodule

// File: tb/tb_pack_n_to_w.sv
// tb_pack_n_to_w: table-driven check of alignment, lock, misalignment and gap handling.
module tb_pack_n_to_w;
  logic clk_f = 1'b0;
  logic reset = 1'b0;
  logic [7:0] data_input = '0;
  logic valid_input = 1'b0;
  logic [31:0] data_out;
  logic valid_out, sinc, err_align;
`ifdef PACK_FLUSH_EN
  logic [3:0] be_out;
`endif
  int total = 0;
  int bad = 0;

  typedef struct {
    logic v;
    logic [7:0] d;
    logic ev;
    logic [31:0] edat;
    logic es;
    logic ee;
  } vec_t;
  vec_t tv[$];

  localparam logic [31:0] H = 32'hBC010203;
  localparam logic [31:0] P = 32'h5AA53CC3;

  pack_n_to_w dut (
    .clk_f      (clk_f),
    .reset      (reset),
    .data_input (data_input),
    .valid_input(valid_input),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .sinc       (sinc),
`ifdef PACK_FLUSH_EN
    .be_out     (be_out),
`endif
    .err_align  (err_align)
  );

  always #5 clk_f = ~clk_f;

  task automatic add(input logic v, input logic [7:0] d, input logic ev, input logic [31:0] edat,
                     input logic es, input logic ee);
    vec_t t;
    t.v = v; t.d = d; t.ev = ev; t.edat = edat; t.es = es; t.ee = ee;
    tv.push_back(t);
  endtask

  task automatic step(input logic v, input logic [7:0] d);
    @(negedge clk_f);
    valid_input = v;
    data_input = d;
    @(posedge clk_f);
    #1;
  endtask

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  task automatic chk_all(input string n, input logic ev, input logic [31:0] edat, input logic es,
                         input logic ee);
    chk({n, "_valid"}, 32'(valid_out), 32'(ev));
    chk({n, "_data"}, data_out, edat);
    chk({n, "_sinc"}, 32'(sinc), 32'(es));
    chk({n, "_err"}, 32'(err_align), 32'(ee));
  endtask

  initial begin
    logic [7:0] w [4];
    w[0] = 8'hBC; w[1] = 8'h01; w[2] = 8'h02; w[3] = 8'h03;
    add(1, 8'h11, 0, 0, 0, 0);
    add(1, 8'h22, 0, 0, 0, 0);
    add(1, 8'h33, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 4; j++) add(1, w[j], 0, 0, k == 3 && j == 3, 0);
    for (int j = 0; j < 3; j++) add(1, w[j], 0, 0, 1, 0);
    add(1, 8'h03, 1, H, 1, 0);
    add(1, 8'hBC, 0, H, 1, 0);
    add(1, 8'h01, 0, H, 1, 0);
    add(1, 8'hBC, 0, H, 0, 1);
    for (int j = 1; j < 4; j++) add(1, w[j], 0, H, 0, 0);
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < 4; j++) add(1, w[j], 0, H, k == 2 && j == 3, 0);
    add(1, 8'h5A, 0, H, 1, 0);
    add(1, 8'hA5, 0, H, 1, 0);
    add(1, 8'h3C, 0, H, 1, 0);
    add(1, 8'hC3, 1, P, 1, 0);

    #12;
    chk_all("reset", 0, 0, 0, 0);
    @(negedge clk_f);
    reset = 1'b1;
    for (int i = 0; i < tv.size(); i++) begin
      step(tv[i].v, tv[i].d);
      chk_all($sformatf("vec%0d", i), tv[i].ev, tv[i].edat, tv[i].es, tv[i].ee);
    end

`ifdef PACK_FLUSH_EN
    chk("be_full", 32'(be_out), 32'hF);
    step(1, 8'hBC);
    step(1, 8'h01);
    chk_all("fl_part", 0, P, 1, 0);
    step(0, 8'h00);
    chk_all("fl_emit", 1, 32'hBC010000, 1, 0);
    chk("fl_be", 32'(be_out), 32'hC);
    step(0, 8'h00);
    chk_all("fl_gap", 0, 32'hBC010000, 1, 0);
    step(1, 8'h01); step(1, 8'h02); step(1, 8'h03); step(1, 8'h04);
    chk_all("fl_full", 1, 32'h01020304, 1, 0);
    chk("fl_be_full", 32'(be_out), 32'hF);
`else
    step(1, 8'hBC);
    step(1, 8'h01);
    for (int g = 0; g < 3; g++) begin
      step(0, 8'h00);
      chk_all($sformatf("gap%0d", g), 0, P, 1, 0);
    end
    step(1, 8'h02);
    chk_all("gap_02", 0, P, 1, 0);
    step(1, 8'h03);
    chk_all("gap_word", 1, H, 1, 0);
    step(1, 8'h11);
    chk_all("gap_after", 0, H, 1, 0);
`endif

    step(1, 8'hBC);
    step(1, 8'h01);
    @(negedge clk_f);
    valid_input = 1'b0;
    reset = 1'b0;
    #2;
    chk_all("async_rst", 0, 0, 0, 0);
    @(negedge clk_f);
    reset = 1'b1;
    step(1, 8'h02);
    step(1, 8'h03);
    chk_all("post_rst", 0, 0, 0, 0);
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 4; j++) begin
        step(1, w[j]);
        if (j == 3) chk_all($sformatf("relock%0d", k), 0, 0, k == 3, 0);
      end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
